// File: rtl/conv_pkg.sv
// Shared types for the conv pixel-stream path.
package conv_pkg;

    localparam int PIXEL_W = 8;

    typedef logic [PIXEL_W-1:0] pixel_t;

endpackage : conv_pkg

// File: rtl/conv_pixel_tx_if.sv
// Pixel bundles around conv_pixel_tx: upstream ready/valid source and the
// backpressure-free stream into the conv line buffer.

interface conv_src_if;

    logic             vld;
    conv_pkg::pixel_t dat;
    logic             rdy;

    modport master (output vld, output dat, input  rdy);
    modport slave  (input  vld, input  dat, output rdy);

endinterface : conv_src_if

interface conv_pix_if;

    logic             vld;
    conv_pkg::pixel_t dat;
    logic             eol;

    modport master (output vld, output dat, output eol);
    modport slave  (input  vld, input  dat, input  eol);

endinterface : conv_pix_if

// File: rtl/conv_pixel_tx.sv
// Source end of the conv pixel stream: paces pixels from a ready/valid producer
// into the line buffer, marks end-of-line and inserts blanking after each line.
module conv_pixel_tx #(
    parameter int W_MAX   = 1920,
    parameter int H_MAX   = 1080,
    parameter int BLANK_N = 2
) (
    input  logic                         clk,
    input  logic                         arst_n,
    input  logic [$clog2(W_MAX+1)-1:0]   cfg_width_i,
    input  logic [$clog2(H_MAX+1)-1:0]   cfg_height_i,
    input  logic                         start_i,
    output logic                         busy_o,
    output logic                         done_o,
    conv_src_if.slave                    src,
    conv_pix_if.master                   pix
);

    localparam int XW         = $clog2(W_MAX + 1);
    localparam int YW         = $clog2(H_MAX + 1);
    localparam int BW         = (BLANK_N > 1) ? $clog2(BLANK_N) : 1;
    localparam int BLANK_INIT = (BLANK_N > 0) ? BLANK_N - 1 : 0;

    localparam logic [XW-1:0] X_ONE   = XW'(1);
    localparam logic [YW-1:0] Y_ONE   = YW'(1);
    localparam logic [XW-1:0] W_LIMIT = XW'(W_MAX);
    localparam logic [YW-1:0] H_LIMIT = YW'(H_MAX);
    localparam logic [BW-1:0] B_ONE   = BW'(1);
    localparam logic [BW-1:0] B_INIT  = BW'(BLANK_INIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LINE  = 2'd1,
        BLANK = 2'd2
    } state_e;

    state_e           state_q;
    logic [XW-1:0]    width_q;
    logic [YW-1:0]    height_q;
    logic [XW-1:0]    x_q;
    logic [YW-1:0]    y_q;
    logic [BW-1:0]    blank_q;
    logic             done_q;
    logic             pix_vld_q;
    logic             pix_eol_q;
    conv_pkg::pixel_t pix_dat_q;

    logic [XW-1:0]    width_d;
    logic [YW-1:0]    height_d;
    logic             accept;
    logic             x_last;
    logic             y_last;

    // Configuration is clamped before latching so the counters can never run
    // past the widths they were sized for.
    assign width_d  = (cfg_width_i  > W_LIMIT) ? W_LIMIT : cfg_width_i;
    assign height_d = (cfg_height_i > H_LIMIT) ? H_LIMIT : cfg_height_i;

    assign accept = (state_q == LINE) && src.vld;
    assign x_last = (x_q == width_q - X_ONE);
    assign y_last = (y_q == height_q - Y_ONE);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q   <= IDLE;
            width_q   <= '0;
            height_q  <= '0;
            x_q       <= '0;
            y_q       <= '0;
            blank_q   <= '0;
            done_q    <= 1'b0;
            pix_vld_q <= 1'b0;
            pix_eol_q <= 1'b0;
            pix_dat_q <= '0;
        end else begin
            // NOTE: every register here uses <= so all of them see the
            // pre-edge values of each other, independent of statement order.
            pix_vld_q <= accept;
            pix_eol_q <= accept && x_last;
            done_q    <= 1'b0;
            if (accept) begin
                pix_dat_q <= src.dat;
            end

            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        width_q  <= width_d;
                        height_q <= height_d;
                        x_q      <= '0;
                        y_q      <= '0;
                        if ((width_d == '0) || (height_d == '0)) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= LINE;
                        end
                    end
                end

                LINE: begin
                    if (src.vld) begin
                        if (x_last) begin
                            x_q <= '0;
                            if (y_last) begin
                                // done_q lands with the final pixel's vld/eol.
                                y_q     <= '0;
                                done_q  <= 1'b1;
                                state_q <= IDLE;
                            end else begin
                                y_q <= y_q + Y_ONE;
                                if (BLANK_N > 0) begin
                                    blank_q <= B_INIT;
                                    state_q <= BLANK;
                                end
                            end
                        end else begin
                            x_q <= x_q + X_ONE;
                        end
                    end
                end

                BLANK: begin
                    if (blank_q == '0) begin
                        state_q <= LINE;
                    end else begin
                        blank_q <= blank_q - B_ONE;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    // Upstream ready decodes the registered state only, so src.vld never
    // reaches src.rdy combinationally.
    assign src.rdy = (state_q == LINE);
    assign busy_o  = (state_q != IDLE);
    assign done_o  = done_q;

    assign pix.vld = pix_vld_q;
    assign pix.dat = pix_dat_q;
    assign pix.eol = pix_eol_q;

endmodule : conv_pixel_tx
